// File: rtl/hangman_round_sequencer.sv
// One hangman round: button edge detect, word fetch from ROM, one-slot-per-cycle
// guess scan, and registered mask / miss / win / lose bookkeeping.
module hangman_round_sequencer #(
  parameter int unsigned LETTERS    = 5,
  parameter int unsigned CHAR_W     = 5,
  parameter int unsigned MAX_MISSES = 7,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                next_btn,
  input  logic [ADDR_W-1:0]                   word_sel,
  input  logic [CHAR_W-1:0]                   guess_char,
  output logic [ADDR_W-1:0]                   rom_addr,
  input  logic [LETTERS*CHAR_W-1:0]           rom_data,
  output logic [LETTERS-1:0]                  guessed_mask,
  output logic [$clog2(MAX_MISSES+1)-1:0]     misses,
  output logic                                win,
  output logic                                lose,
  output logic                                busy,
  output logic                                hit_pulse,
  output logic                                miss_pulse,
  output logic                                repeat_pulse
);

  localparam int unsigned WORD_W = LETTERS * CHAR_W;
  localparam int unsigned MISS_W = $clog2(MAX_MISSES + 1);
  localparam int unsigned IDX_W  = $clog2(LETTERS + 1);
  localparam int unsigned CNT_W  = $clog2(ROM_LAT + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_GUESS, S_SCAN, S_COMMIT, S_WIN, S_LOSE
  } state_t;

  state_t              r_state, w_state_nx;
  logic                r_sync1, r_sync2, r_prev;
  logic [ADDR_W-1:0]   r_addr, w_addr_nx;
  logic [WORD_W-1:0]   r_word, w_word_nx;
  logic [CHAR_W-1:0]   r_char, w_char_nx;
  logic [LETTERS-1:0]  r_acc, w_acc_nx;
  logic [IDX_W-1:0]    r_idx, w_idx_nx;
  logic [CNT_W-1:0]    r_fcnt, w_fcnt_nx;
  logic [LETTERS-1:0]  r_mask, w_mask_nx;
  logic [MISS_W-1:0]   r_misses, w_misses_nx;
  logic                r_win, w_win_nx, r_lose, w_lose_nx, r_busy, w_busy_nx;
  logic                r_hit, w_hit_nx, r_miss, w_miss_nx, r_rep, w_rep_nx;

  logic                w_next_evt;
  logic [LETTERS-1:0]  w_blank, w_acc_scan, w_new;
  logic [MISS_W-1:0]   w_miss_inc;

  assign w_next_evt = r_sync2 & ~r_prev;

  // Blank-slot preset from the ROM word and the current scan slot compare.
  always_comb begin
    w_blank    = '0;
    w_acc_scan = r_acc;
    for (int i = 0; i < LETTERS; i++) begin
      w_blank[LETTERS-1-i] = (rom_data[(LETTERS-i)*CHAR_W-1 -: CHAR_W] == '0);
      if (r_idx == IDX_W'(i))
        w_acc_scan[LETTERS-1-i] = (r_word[(LETTERS-i)*CHAR_W-1 -: CHAR_W] == r_char);
    end
    w_new      = r_acc & ~r_mask;
    w_miss_inc = (r_misses == MISS_W'(MAX_MISSES)) ? r_misses : r_misses + MISS_W'(1);
  end

  always_comb begin
    w_state_nx  = r_state;
    w_addr_nx   = r_addr;
    w_word_nx   = r_word;
    w_char_nx   = r_char;
    w_acc_nx    = r_acc;
    w_idx_nx    = r_idx;
    w_fcnt_nx   = r_fcnt;
    w_mask_nx   = r_mask;
    w_misses_nx = r_misses;
    w_win_nx    = r_win;
    w_lose_nx   = r_lose;
    w_hit_nx    = 1'b0;
    w_miss_nx   = 1'b0;
    w_rep_nx    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_mask_nx   = '0;
        w_misses_nx = '0;
        w_win_nx    = 1'b0;
        w_lose_nx   = 1'b0;
        if (w_next_evt) begin
          w_addr_nx  = word_sel;
          w_fcnt_nx  = '0;
          w_state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        if (r_fcnt == CNT_W'(ROM_LAT)) begin
          w_word_nx = rom_data;
          w_mask_nx = w_blank;
          if (&w_blank) begin
            w_win_nx   = 1'b1;
            w_state_nx = S_WIN;
          end else begin
            w_state_nx = S_GUESS;
          end
        end else begin
          w_fcnt_nx = r_fcnt + CNT_W'(1);
        end
      end
      S_GUESS: begin
        if (w_next_evt && (guess_char != '0)) begin
          w_char_nx  = guess_char;
          w_acc_nx   = '0;
          w_idx_nx   = '0;
          w_state_nx = S_SCAN;
        end
      end
      S_SCAN: begin
        w_acc_nx = w_acc_scan;
        w_idx_nx = r_idx + IDX_W'(1);
        if (r_idx == IDX_W'(LETTERS - 1))
          w_state_nx = S_COMMIT;
      end
      S_COMMIT: begin
        if (r_acc == '0) begin
          w_misses_nx = w_miss_inc;
          w_miss_nx   = 1'b1;
          if (w_miss_inc == MISS_W'(MAX_MISSES)) begin
            w_lose_nx  = 1'b1;
            w_state_nx = S_LOSE;
          end else begin
            w_state_nx = S_GUESS;
          end
        end else if (w_new == '0) begin
          w_rep_nx   = 1'b1;
          w_state_nx = S_GUESS;
        end else begin
          w_mask_nx = r_mask | r_acc;
          w_hit_nx  = 1'b1;
          if (&(r_mask | r_acc)) begin
            w_win_nx   = 1'b1;
            w_state_nx = S_WIN;
          end else begin
            w_state_nx = S_GUESS;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (w_next_evt) begin
          w_mask_nx   = '0;
          w_misses_nx = '0;
          w_win_nx    = 1'b0;
          w_lose_nx   = 1'b0;
          w_state_nx  = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    w_busy_nx = (w_state_nx == S_FETCH) || (w_state_nx == S_SCAN) ||
                (w_state_nx == S_COMMIT);
  end

  // Button flops reset high so a button held through reset gives no event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_prev   <= 1'b1;
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_word   <= '0;
      r_char   <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_fcnt   <= '0;
      r_mask   <= '0;
      r_misses <= '0;
      r_win    <= 1'b0;
      r_lose   <= 1'b0;
      r_busy   <= 1'b0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_rep    <= 1'b0;
    end else begin
      r_sync1  <= next_btn;
      r_sync2  <= r_sync1;
      r_prev   <= r_sync2;
      r_state  <= w_state_nx;
      r_addr   <= w_addr_nx;
      r_word   <= w_word_nx;
      r_char   <= w_char_nx;
      r_acc    <= w_acc_nx;
      r_idx    <= w_idx_nx;
      r_fcnt   <= w_fcnt_nx;
      r_mask   <= w_mask_nx;
      r_misses <= w_misses_nx;
      r_win    <= w_win_nx;
      r_lose   <= w_lose_nx;
      r_busy   <= w_busy_nx;
      r_hit    <= w_hit_nx;
      r_miss   <= w_miss_nx;
      r_rep    <= w_rep_nx;
    end
  end

  assign rom_addr     = r_addr;
  assign guessed_mask = r_mask;
  assign misses       = r_misses;
  assign win          = r_win;
  assign lose         = r_lose;
  assign busy         = r_busy;
  assign hit_pulse    = r_hit;
  assign miss_pulse   = r_miss;
  assign repeat_pulse = r_rep;

endmodule

// File: tb/tb_hangman_round_sequencer.sv
// Bench for hangman_round_sequencer: directed rounds plus random rounds checked
// against a slot-level game model, with a latency-2 ROM.
module tb_hangman_round_sequencer;

  localparam int unsigned LETTERS    = 5;
  localparam int unsigned CHAR_W     = 5;
  localparam int unsigned MAX_MISSES = 7;
  localparam int unsigned ROM_LAT    = 2;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned WORD_W     = LETTERS * CHAR_W;
  localparam int unsigned MISS_W     = $clog2(MAX_MISSES + 1);

  logic                clk, reset, next_btn;
  logic [ADDR_W-1:0]   word_sel, rom_addr;
  logic [CHAR_W-1:0]   guess_char;
  logic [WORD_W-1:0]   rom_data, rom_d1;
  logic [LETTERS-1:0]  guessed_mask;
  logic [MISS_W-1:0]   misses;
  logic                win, lose, busy, hit_pulse, miss_pulse, repeat_pulse;

  hangman_round_sequencer #(
    .LETTERS(LETTERS), .CHAR_W(CHAR_W), .MAX_MISSES(MAX_MISSES),
    .ROM_LAT(ROM_LAT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .next_btn(next_btn), .word_sel(word_sel),
    .guess_char(guess_char), .rom_addr(rom_addr), .rom_data(rom_data),
    .guessed_mask(guessed_mask), .misses(misses), .win(win), .lose(lose),
    .busy(busy), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .repeat_pulse(repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage ROM read pipeline.
  logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    rom_d1   <= mem[rom_addr];
    rom_data <= rom_d1;
  end

  int total = 0;
  int bad   = 0;

  // Game model: per-slot letters and reveal flags.
  int  m_slot [LETTERS];
  bit  m_rev  [LETTERS];
  int  m_miss;
  bit  m_win, m_lose;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_mask();
    logic [31:0] m;
    m = 0;
    for (int i = 0; i < LETTERS; i++)
      if (m_rev[i]) m = m | (32'd1 << (LETTERS - 1 - i));
    return m;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LETTERS; i++) begin
      m_slot[i] = 0;
      m_rev[i]  = 1'b0;
    end
    m_miss = 0;
    m_win  = 1'b0;
    m_lose = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mask"},   32'(guessed_mask), 32'd0);
    check({tag, "_misses"}, 32'(misses), 32'd0);
    check({tag, "_winlose"}, {30'd0, win, lose}, 32'd0);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_pulses"}, {29'd0, hit_pulse, miss_pulse, repeat_pulse}, 32'd0);
  endtask

  task automatic start_round(input int a);
    logic [WORD_W-1:0] w;
    int bcnt;
    bit all_rev;
    w = mem[a];
    all_rev = 1'b1;
    for (int i = 0; i < LETTERS; i++) begin
      m_slot[i] = int'(w[(LETTERS-i)*CHAR_W-1 -: CHAR_W]);
      m_rev[i]  = (m_slot[i] == 0);
      if (!m_rev[i]) all_rev = 1'b0;
    end
    m_miss = 0;
    m_win  = all_rev;
    m_lose = 1'b0;
    word_sel = ADDR_W'(a);
    next_btn = 1'b1;
    bcnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) next_btn = 1'b0;
      if (busy) bcnt++;
    end
    check("fetch_busy_cycles", 32'(bcnt), ROM_LAT + 1);
    check("fetch_rom_addr", 32'(rom_addr), 32'(a));
    check("fetch_mask", 32'(guessed_mask), exp_mask());
    check("fetch_win", 32'(win), 32'(m_win));
    check("fetch_misses", 32'(misses), 32'd0);
  endtask

  // One guess press; dbl re-presses the button while the scan is running.
  task automatic guess(input logic [CHAR_W-1:0] c, input bit dbl);
    int n, pcnt, nhit, nnew;
    bit seen, bseen, ph, pm, pr, pw, pl, e_hit, e_miss, e_rep;
    nhit = 0; nnew = 0;
    for (int i = 0; i < LETTERS; i++)
      if (m_slot[i] == int'(c)) begin
        nhit++;
        if (!m_rev[i]) nnew++;
      end
    e_hit = 1'b0; e_miss = 1'b0; e_rep = 1'b0;
    if (c != '0) begin
      if (nhit == 0) begin
        e_miss = 1'b1;
        m_miss++;
        if (m_miss == MAX_MISSES) m_lose = 1'b1;
      end else if (nnew == 0) begin
        e_rep = 1'b1;
      end else begin
        e_hit = 1'b1;
        m_win = 1'b1;
        for (int i = 0; i < LETTERS; i++) begin
          if (m_slot[i] == int'(c)) m_rev[i] = 1'b1;
          if (!m_rev[i]) m_win = 1'b0;
        end
      end
    end
    guess_char = c;
    next_btn = 1'b1;
    n = 0; pcnt = 0; seen = 0; bseen = 0;
    ph = 0; pm = 0; pr = 0; pw = 0; pl = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 3) next_btn = 1'b0;
      if (dbl && k == 5) next_btn = 1'b1;
      if (dbl && k == 12) next_btn = 1'b0;
      if (busy) bseen = 1'b1;
      if (hit_pulse | miss_pulse | repeat_pulse) begin
        pcnt++;
        if (!seen) begin
          seen = 1'b1; n = k;
          ph = hit_pulse; pm = miss_pulse; pr = repeat_pulse;
          pw = win; pl = lose;
        end
      end
    end
    if (c == '0) begin
      check("blank_busy", 32'(bseen), 32'd0);
      check("blank_pulses", 32'(pcnt), 32'd0);
    end else begin
      check("guess_latency", 32'(n), 2 + 1 + LETTERS + 1);
      check("guess_pulse_count", 32'(pcnt), 32'd1);
      check("guess_pulse_kind", {29'd0, ph, pm, pr}, {29'd0, e_hit, e_miss, e_rep});
      check("guess_winlose_at_commit", {30'd0, pw, pl}, {30'd0, m_win, m_lose});
    end
    check("guess_mask", 32'(guessed_mask), exp_mask());
    check("guess_misses", 32'(misses), 32'(m_miss));
    check("guess_win", 32'(win), 32'(m_win));
    check("guess_lose", 32'(lose), 32'(m_lose));
  endtask

  task automatic end_round();
    next_btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 3) next_btn = 1'b0;
    end
    check_all_zero("end_round");
    model_clear();
  endtask

  initial begin
    int bcnt;
    reset = 1'b1; next_btn = 1'b0; word_sel = '0; guess_char = '0;
    model_clear();
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      mem[a] = '0;
      for (int i = 0; i < LETTERS; i++)
        mem[a][(LETTERS-i)*CHAR_W-1 -: CHAR_W] = CHAR_W'($urandom_range(0, 5));
    end
    mem[0] = {5'd13, 5'd14, 5'd19, 5'd17, 5'd5};
    mem[3] = {5'd3, 5'd3, 5'd4, 5'd0, 5'd0};
    step(); step();
    check_all_zero("reset");
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    reset = 1'b0;
    step(); step(); step();

    // Full win, one guess re-pressing the button during the scan.
    start_round(0);
    guess(5'd13, 1'b0);
    guess(5'd14, 1'b0);
    guess(5'd19, 1'b1);
    guess(5'd17, 1'b0);
    guess(5'd5,  1'b0);
    end_round();

    // Loss by seven misses.
    start_round(0);
    for (int g = 0; g < 7; g++) guess(5'd1, 1'b0);
    end_round();

    // Duplicate letters, blank preset, repeat and blank guesses.
    start_round(3);
    guess(5'd3, 1'b0);
    guess(5'd3, 1'b0);
    guess(5'd0, 1'b0);
    guess(5'd4, 1'b0);
    end_round();

    // Reset in the middle of a scan with the button held through reset.
    start_round(0);
    guess(5'd13, 1'b0);
    guess_char = 5'd14;
    next_btn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 3) next_btn = 1'b0;
    end
    next_btn = 1'b1;
    reset = 1'b1;
    step();
    check_all_zero("reset_mid_scan");
    model_clear();
    step();
    reset = 1'b0;
    word_sel = 6'd3;
    bcnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (busy) bcnt++;
    end
    check("held_btn_no_fetch", 32'(bcnt), 32'd0);
    check("held_btn_rom_addr", 32'(rom_addr), 32'd0);
    next_btn = 1'b0;
    step(); step(); step();
    start_round(3);
    guess(5'd3, 1'b0);
    guess(5'd4, 1'b0);
    end_round();

    // Random rounds over random words.
    for (int r = 0; r < 6; r++) begin
      start_round(8 + r);
      for (int g = 0; g < 20 && !m_win && !m_lose; g++)
        guess(CHAR_W'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      if (m_win || m_lose) begin
        end_round();
      end else begin
        reset = 1'b1;
        step();
        check_all_zero("random_reset");
        model_clear();
        reset = 1'b0;
        step(); step(); step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hangman_round_sequencer.md
# hangman_round_sequencer

Sequencer that runs one hangman round against the word ROM: it debounces-by-edge the player's `next` button, fetches the selected word, scans the guessed character across the letter slots one slot per cycle, and maintains the guessed-letter mask, miss counter and win/lose flags. It sits between the chip I/O (button, word select, character switches) and the word ROM. It replaces the combinational-latch style of bookkeeping with fully registered state and explicit busy/event handshakes.

## Interface
- `LETTERS`, 5: letter slots per word; slot 0 occupies the MSBs of the ROM word.
- `CHAR_W`, 5: bits per character; code 0 is a blank/padding character.
- `MAX_MISSES`, 7: the round is lost when the miss count reaches this value.
- `ROM_LAT`, 1: cycles from `rom_addr` valid to `rom_data` valid (≥1).
- `ADDR_W`, 6: word-select and ROM address width.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `next_btn` in 1: raw asynchronous player button.
- `word_sel` in ADDR_W: word index, sampled on a new-round event.
- `guess_char` in CHAR_W: guessed character, sampled on a guess event.
- `rom_addr` out ADDR_W: registered ROM address.
- `rom_data` in LETTERS*CHAR_W: ROM word; slot i = bits [(LETTERS-i)*CHAR_W-1 -: CHAR_W].
- `guessed_mask` out LETTERS: bit LETTERS-1-i set when slot i is revealed.
- `misses` out clog2(MAX_MISSES+1): wrong-guess count.
- `win`, `lose` out 1: registered round result.
- `busy` out 1: high in FETCH, SCAN and COMMIT.
- `hit_pulse`, `miss_pulse`, `repeat_pulse` out 1: single-cycle guess outcome.

## Operation
- Button path: two-flop synchronizer, then a `prev` flop; `next_evt = sync2 & ~prev`. All three flops reset to 1, so a button held through reset produces no event until it is released and pressed again.
- States: IDLE, FETCH, GUESS, SCAN, COMMIT, WIN, LOSE.
- IDLE: mask, misses, win and lose are held at 0. On `next_evt`, `rom_addr <= word_sel` and the FSM moves to FETCH.
- FETCH: wait ROM_LAT cycles, then capture `rom_data` into `word_reg`. Mask bits for slots equal to 0 are preset to 1. If the mask is then full, go to WIN; otherwise go to GUESS.
- GUESS: on `next_evt` with `guess_char != 0`, latch `char_reg`, clear `acc`, set `idx = 0` and go to SCAN. An event with `guess_char == 0` is ignored and the FSM stays in GUESS.
- SCAN: each cycle, `acc[LETTERS-1-idx] <= (word_reg slot idx == char_reg)` and `idx` increments. After slot LETTERS-1, go to COMMIT.
- COMMIT: `new = acc & ~guessed_mask`.
  - If `acc == 0`: miss. `misses += 1` and `miss_pulse` fires. If the new count equals MAX_MISSES, go to LOSE; otherwise go to GUESS.
  - Else if `new == 0`: repeat. `repeat_pulse` fires and `misses` is unchanged. Go to GUESS.
  - Else: `guessed_mask |= acc` and `hit_pulse` fires. If the mask is full, go to WIN; otherwise go to GUESS.
- A character that appears in several slots reveals all of those slots in one guess.
- WIN/LOSE: `win`/`lose` = 1 and all outputs hold. On `next_evt`, go to IDLE, which clears mask, misses, win and lose.
- `next_evt` while `busy` is dropped, not queued.
- `misses` saturates at MAX_MISSES, which is unreachable outside LOSE.

## Timing
- Reset values: `rom_addr` 0, `guessed_mask` 0, `misses` 0, `win` 0, `lose` 0, `busy` 0, all pulses 0. State is IDLE and `acc`, `idx`, `word_reg`, `char_reg` are 0.
- A raw button rise is seen on `next_evt` 2 edges later. The state changes on the following edge.
- Fetch takes ROM_LAT+1 cycles in FETCH, counted from the IDLE→FETCH edge to the FETCH→GUESS/WIN edge.
- Guess: 1 GUESS-event cycle, LETTERS SCAN cycles, 1 COMMIT cycle.
  - `guessed_mask`, `misses` and pulses update on the COMMIT edge.
  - Pulses are high for exactly the one cycle after that edge.
  - `win`/`lose` rise on the same edge.
- Reset mid-operation, in any state, returns to the reset values on the next edge. No partial guess is committed.

## Test plan
- Full win: word_sel=0, rom_data=01101_01110_10011_10001_00101 (13,14,19,17,5); guesses 13,14,19,17,5 → mask 10000, 11000, 11100, 11110, 11111; `win`=1 on the 5th COMMIT; misses=0; 5 `hit_pulse`s.
- Loss: same word, guess 1 seven times → misses 1..7, `lose`=1 after the 7th COMMIT, mask 00000, 7 `miss_pulse`s. Then `next` → IDLE with all outputs 0.
- Repeat/duplicate: word 3,3,4,0,0 → mask preset 00011 after fetch. Guess 3 → mask 11011 in one hit. Guess 3 again → `repeat_pulse`, misses 0. Guess 4 → mask 11111, `win`=1.
- Timing/busy: ROM_LAT=2. Measure the edge count from `next_btn` rise to a mask update equal to 2+1+LETTERS+1. A second `next_btn` press during SCAN is ignored: exactly one COMMIT occurs.
- Reset: assert reset during SCAN → mask, misses, win, lose 0 and state IDLE. Hold `next_btn` high through reset → no fetch until release and re-press.
- Blank guess: `guess_char=0` with `next` in GUESS → no SCAN, `busy` stays 0, no pulses, misses unchanged.
